// File: rtl/issue_queue.sv
// issue_queue: in-order decoded-instruction FIFO feeding the reservation
// station (ALU/branch ops) and the load/store buffer (memory ops).
// The head entry is dispatched combinationally once its destination, a ROB
// entry and (for ALU ops) a free RS slot are available; a blocked head
// blocks everything queued behind it.
module issue_queue #(
  parameter int IQ_DEPTH   = 16,
  parameter int RS_SIZE    = 16,
  parameter int RS_IDX_W   = 4,
  parameter int INSTR_ID_W = 6,
  parameter int IMM_W      = 32,
  parameter int REG_IDX_W  = 5,
  parameter int ADDR_W     = 32,
  parameter int ROB_IDX_W  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,

  input  logic                  dec_en_in,
  input  logic [INSTR_ID_W-1:0] dec_instr_id_in,
  input  logic [IMM_W-1:0]      dec_imm_in,
  input  logic [REG_IDX_W-1:0]  dec_rs1_in,
  input  logic [REG_IDX_W-1:0]  dec_rs2_in,
  input  logic [REG_IDX_W-1:0]  dec_rd_in,
  input  logic [ADDR_W-1:0]     dec_pc_in,
  input  logic                  dec_is_ls_in,
  output logic                  iq_full_out,

  input  logic [RS_SIZE-1:0]    rs_busy_status_in,
  input  logic                  rob_full_in,
  input  logic [ROB_IDX_W-1:0]  rob_tail_in,
  input  logic                  lsb_full_in,

  output logic                  issue_to_rs_en_out,
  output logic                  issue_to_lsb_en_out,
  output logic                  issue_to_rob_en_out,
  output logic [RS_IDX_W-1:0]   rs_pos_out,
  output logic [ROB_IDX_W-1:0]  rob_pos_out,

  output logic [INSTR_ID_W-1:0] instr_id_out,
  output logic [IMM_W-1:0]      imm_out,
  output logic [REG_IDX_W-1:0]  rs1_out,
  output logic [REG_IDX_W-1:0]  rs2_out,
  output logic [REG_IDX_W-1:0]  rd_out,
  output logic [ADDR_W-1:0]     pc_out,

  input  logic                  clear_branch_in
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IQ_DEPTH);

  // Payload storage (intentionally not reset; validity is tracked by count)
  logic [INSTR_ID_W-1:0] instr_id_mem [IQ_DEPTH];
  logic [IMM_W-1:0]      imm_mem      [IQ_DEPTH];
  logic [REG_IDX_W-1:0]  rs1_mem      [IQ_DEPTH];
  logic [REG_IDX_W-1:0]  rs2_mem      [IQ_DEPTH];
  logic [REG_IDX_W-1:0]  rd_mem       [IQ_DEPTH];
  logic [ADDR_W-1:0]     pc_mem       [IQ_DEPTH];
  logic                  is_ls_mem    [IQ_DEPTH];

  // Queue control state
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Dispatch decision signals
  logic              rs_free;
  logic [RS_IDX_W-1:0] rs_sel;
  logic              not_empty;
  logic              head_is_ls;
  logic              go;
  logic              rs_en;
  logic              lsb_en;
  logic              pop;
  logic              push;

  // Pick the lowest-numbered idle RS slot (scan from the top so the lowest wins)
  always_comb begin
    rs_free = 1'b0;
    rs_sel  = {RS_IDX_W{1'b0}};
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      rs_sel  = rs_busy_status_in[i] ? rs_sel : RS_IDX_W'(i);
      rs_free = rs_free | ~rs_busy_status_in[i];
    end
  end

  // Head dispatch and push acceptance; a flush or a freeze suppresses both
  always_comb begin
    not_empty  = (count != {CNT_W{1'b0}});
    head_is_ls = is_ls_mem[head];
    go         = rdy_in & ~clear_branch_in & not_empty & ~rob_full_in;
    rs_en      = go & ~head_is_ls & rs_free;
    lsb_en     = go &  head_is_ls & ~lsb_full_in;
    pop        = rs_en | lsb_en;
    // Fullness is judged on the current count, so a push into a full queue
    // is dropped even when the head leaves on the same edge.
    push       = rdy_in & ~clear_branch_in & dec_en_in & (count != DEPTH_CNT);
  end

  // Next pointer/count values; flush wins over push and pop
  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    if (rdy_in && clear_branch_in) begin
      head_nxt  = {PTR_W{1'b0}};
      tail_nxt  = {PTR_W{1'b0}};
      count_nxt = {CNT_W{1'b0}};
    end else begin
      if (push) begin
        tail_nxt = tail + PTR_W'(1);
      end else begin
        tail_nxt = tail;
      end
      if (pop) begin
        head_nxt = head + PTR_W'(1);
      end else begin
        head_nxt = head;
      end
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Pointer, count and full-flag registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head        <= {PTR_W{1'b0}};
      tail        <= {PTR_W{1'b0}};
      count       <= {CNT_W{1'b0}};
      iq_full_out <= 1'b0;
    end else begin
      head        <= head_nxt;
      tail        <= tail_nxt;
      count       <= count_nxt;
      iq_full_out <= (count_nxt == DEPTH_CNT);
    end
  end

  // Write the decoded instruction at the tail when a push is accepted
  always_ff @(posedge clk_in) begin
    if (push) begin
      instr_id_mem[tail] <= dec_instr_id_in;
      imm_mem[tail]      <= dec_imm_in;
      rs1_mem[tail]      <= dec_rs1_in;
      rs2_mem[tail]      <= dec_rs2_in;
      rd_mem[tail]       <= dec_rd_in;
      pc_mem[tail]       <= dec_pc_in;
      is_ls_mem[tail]    <= dec_is_ls_in;
    end
  end

  // Dispatch strobes, slot choice and head payload toward RS/LSB/ROB/regfile
  always_comb begin
    issue_to_rs_en_out  = rs_en;
    issue_to_lsb_en_out = lsb_en;
    issue_to_rob_en_out = pop;
    rs_pos_out          = rs_sel;
    rob_pos_out         = rob_tail_in;
    instr_id_out        = instr_id_mem[head];
    imm_out             = imm_mem[head];
    rs1_out             = rs1_mem[head];
    rs2_out             = rs2_mem[head];
    rd_out              = rd_mem[head];
    pc_out              = pc_mem[head];
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: per-cycle vector table for the basic
// dispatch cases, then hand-written sequences for fill/drain, flush and a
// scoreboarded random interleaving.
module tb_issue_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dec_en_in;
  logic [5:0]  dec_instr_id_in;
  logic [31:0] dec_imm_in;
  logic [4:0]  dec_rs1_in;
  logic [4:0]  dec_rs2_in;
  logic [4:0]  dec_rd_in;
  logic [31:0] dec_pc_in;
  logic        dec_is_ls_in;
  logic        iq_full_out;
  logic [15:0] rs_busy_status_in;
  logic        rob_full_in;
  logic [3:0]  rob_tail_in;
  logic        lsb_full_in;
  logic        issue_to_rs_en_out;
  logic        issue_to_lsb_en_out;
  logic        issue_to_rob_en_out;
  logic [3:0]  rs_pos_out;
  logic [3:0]  rob_pos_out;
  logic [5:0]  instr_id_out;
  logic [31:0] imm_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic [31:0] pc_out;
  logic        clear_branch_in;

  int checks = 0;
  int errors = 0;

  issue_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_en_in(dec_en_in), .dec_instr_id_in(dec_instr_id_in), .dec_imm_in(dec_imm_in),
    .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in), .dec_rd_in(dec_rd_in),
    .dec_pc_in(dec_pc_in), .dec_is_ls_in(dec_is_ls_in), .iq_full_out(iq_full_out),
    .rs_busy_status_in(rs_busy_status_in), .rob_full_in(rob_full_in),
    .rob_tail_in(rob_tail_in), .lsb_full_in(lsb_full_in),
    .issue_to_rs_en_out(issue_to_rs_en_out), .issue_to_lsb_en_out(issue_to_lsb_en_out),
    .issue_to_rob_en_out(issue_to_rob_en_out), .rs_pos_out(rs_pos_out),
    .rob_pos_out(rob_pos_out), .instr_id_out(instr_id_out), .imm_out(imm_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .pc_out(pc_out),
    .clear_branch_in(clear_branch_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        dec_en;
    logic        is_ls;
    logic [31:0] pc;
    logic [15:0] busy;
    logic        rob_full;
    logic        lsb_full;
    logic        rdy;
    logic        e_rs;
    logic        e_lsb;
    logic [31:0] e_pc;
    logic [3:0]  e_pos;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a decoder push; the payload fields are derived from pc
  task automatic set_dec(input logic en, input logic ls, input logic [31:0] pc);
    dec_en_in       = en;
    dec_is_ls_in    = ls;
    dec_pc_in       = pc;
    dec_imm_in      = ~pc;
    dec_rd_in       = pc[6:2];
    dec_rs1_in      = pc[7:3];
    dec_rs2_in      = pc[8:4];
    dec_instr_id_in = pc[9:4];
  endtask

  task automatic check_out(input string name, input logic e_rs, input logic e_lsb,
                           input logic [31:0] e_pc, input logic [3:0] e_pos, input logic e_full);
    check({name, ".rs_en"}, {63'd0, issue_to_rs_en_out}, {63'd0, e_rs});
    check({name, ".lsb_en"}, {63'd0, issue_to_lsb_en_out}, {63'd0, e_lsb});
    check({name, ".rob_en"}, {63'd0, issue_to_rob_en_out}, {63'd0, e_rs | e_lsb});
    check({name, ".full"}, {63'd0, iq_full_out}, {63'd0, e_full});
    if (e_rs || e_lsb) begin
      check({name, ".pc"}, {32'd0, pc_out}, {32'd0, e_pc});
      check({name, ".imm"}, {32'd0, imm_out}, {32'd0, ~e_pc});
      check({name, ".rd"}, {59'd0, rd_out}, {59'd0, e_pc[6:2]});
      check({name, ".rs1"}, {59'd0, rs1_out}, {59'd0, e_pc[7:3]});
      check({name, ".rs2"}, {59'd0, rs2_out}, {59'd0, e_pc[8:4]});
      check({name, ".instr_id"}, {58'd0, instr_id_out}, {58'd0, e_pc[9:4]});
      check({name, ".rob_pos"}, {60'd0, rob_pos_out}, {60'd0, rob_tail_in});
    end
    if (e_rs) begin
      check({name, ".rs_pos"}, {60'd0, rs_pos_out}, {60'd0, e_pos});
    end
  endtask

  logic [31:0] q[$];
  int          pushed;
  int          popped;
  logic        do_push;
  logic        go;
  logic        hls;
  logic        ers;
  logic        elsb;
  logic [31:0] hpc;
  logic [31:0] npc;
  int          qsz;

  initial begin
    // 1. three ALU ops, RS slots filling 0,1,2
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'h4,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   4'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h8,   16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4,   4'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   16'h0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8,   4'd2};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   16'h0007, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    // 2. all RS slots busy, then slot 5 frees
    vecs[5]  = '{1'b1, 1'b0, 32'h100, 16'hffff, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   16'hffff, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   16'hffdf, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 4'd5};
    // 3. load blocked by full LSB keeps the ALU op behind it waiting
    vecs[8]  = '{1'b1, 1'b1, 32'h200, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[9]  = '{1'b1, 1'b0, 32'h204, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 4'd0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 4'd0};
    // freeze: rdy low gates dispatch and drops the push
    vecs[13] = '{1'b1, 1'b0, 32'h300, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[14] = '{1'b1, 1'b0, 32'h304, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 4'd0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    // ROB full stalls the head
    vecs[17] = '{1'b1, 1'b0, 32'h400, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,   16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};
    vecs[19] = '{1'b0, 1'b0, 32'h0,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 4'd0};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   4'd0};

    rst_in            = 1'b1;
    rdy_in            = 1'b1;
    rs_busy_status_in = 16'h0000;
    rob_full_in       = 1'b0;
    rob_tail_in       = 4'd0;
    lsb_full_in       = 1'b0;
    clear_branch_in   = 1'b0;
    set_dec(1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_out("reset", 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk_in);
      set_dec(vecs[i].dec_en, vecs[i].is_ls, vecs[i].pc);
      rs_busy_status_in = vecs[i].busy;
      rob_full_in       = vecs[i].rob_full;
      lsb_full_in       = vecs[i].lsb_full;
      rdy_in            = vecs[i].rdy;
      rob_tail_in       = 4'(i + 3);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].e_rs, vecs[i].e_lsb, vecs[i].e_pc, vecs[i].e_pos, 1'b0);
    end

    // 4. fill to 16 with the ROB full, 17th push dropped, then drain
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_in);
      set_dec(1'b1, 1'b0, 32'h1000 + 32'(k * 4));
      rob_full_in = 1'b1;
      #1;
      check_out($sformatf("fill%0d", k), 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);
    end
    @(negedge clk_in);
    set_dec(1'b1, 1'b0, 32'hdead);
    #1;
    check_out("fill_17th", 1'b0, 1'b0, 32'h0, 4'd0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk_in);
      // push attempted while full and popping: must also be dropped
      set_dec(j == 0, 1'b0, 32'hbeef);
      rob_full_in = 1'b0;
      rob_tail_in = 4'(j);
      #1;
      check_out($sformatf("drain%0d", j), 1'b1, 1'b0, 32'h1000 + 32'(j * 4), 4'd0, j == 0);
    end
    @(negedge clk_in);
    set_dec(1'b0, 1'b0, 32'h0);
    #1;
    check_out("drain_empty", 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);

    // 5. flush with a concurrent push
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      set_dec(1'b1, 1'b0, 32'h5000 + 32'(k * 4));
      rob_full_in = 1'b1;
      #1;
      check_out($sformatf("pre_flush%0d", k), 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);
    end
    @(negedge clk_in);
    set_dec(1'b1, 1'b0, 32'h5555);
    rob_full_in     = 1'b0;
    clear_branch_in = 1'b1;
    #1;
    check_out("flush", 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);
    @(negedge clk_in);
    set_dec(1'b0, 1'b0, 32'h0);
    clear_branch_in = 1'b0;
    #1;
    check_out("post_flush", 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);
    @(negedge clk_in);
    set_dec(1'b1, 1'b0, 32'h6000);
    #1;
    check_out("repush", 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);
    @(negedge clk_in);
    set_dec(1'b0, 1'b0, 32'h0);
    #1;
    check_out("repush_go", 1'b1, 1'b0, 32'h6000, 4'd0, 1'b0);
    @(negedge clk_in);
    #1;
    check_out("repush_empty", 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);

    // 6. random interleaving against a scoreboard queue
    pushed = 0;
    popped = 0;
    q.delete();
    for (int cyc = 0; cyc < 1000 && (pushed < 40 || q.size() != 0); cyc++) begin
      @(negedge clk_in);
      rdy_in            = ($urandom_range(0, 7) != 0);
      rob_full_in       = ($urandom_range(0, 3) == 0);
      lsb_full_in       = ($urandom_range(0, 3) == 0);
      rs_busy_status_in = ($urandom_range(0, 4) == 0) ? 16'hffff : 16'h0000;
      rob_tail_in       = 4'(cyc);
      do_push           = (pushed < 40) && ($urandom_range(0, 2) != 0);
      npc               = 32'h2000 + 32'(pushed * 4);
      set_dec(do_push, npc[3], npc);
      #1;
      qsz  = q.size();
      hpc  = (qsz != 0) ? q[0] : 32'h0;
      hls  = hpc[3];
      go   = rdy_in & ~rob_full_in & (qsz != 0);
      ers  = go & ~hls & (rs_busy_status_in != 16'hffff);
      elsb = go & hls & ~lsb_full_in;
      check_out($sformatf("wrap%0d", cyc), ers, elsb, hpc, 4'd0, qsz == 16);
      if (ers || elsb) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push && rdy_in && qsz < 16) begin
        q.push_back(npc);
        pushed++;
      end
    end
    check("wrap.pushed", 64'(pushed), 64'd40);
    check("wrap.popped", 64'(popped), 64'd40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
